// File: rtl/activation_scheduler_if.sv
// Handshake and shared-unit bundle for activation_scheduler.
// slave = the scheduler itself, master = the producer/consumer/shared unit side.
interface activation_scheduler_if #(
  parameter int N_NEURONS = 2,
  parameter int DATA_W    = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [N_NEURONS*DATA_W-1:0]   in_z;
  logic [DATA_W-1:0]             fn_z;
  logic [DATA_W-1:0]             fn_a;
  logic                          out_valid;
  logic                          out_ready;
  logic [N_NEURONS*DATA_W-1:0]   out_a;
  logic                          busy;

  modport slave (
    input  in_valid, in_z, fn_a, out_ready,
    output in_ready, fn_z, out_valid, out_a, busy
  );

  modport master (
    output in_valid, in_z, fn_a, out_ready,
    input  in_ready, fn_z, out_valid, out_a, busy
  );
endinterface

// File: rtl/activation_scheduler.sv
// Shares one activation unit across a layer: latch z vector, issue one element per cycle, collect results.
// ACT_SCHED_REG_RETURN_EN: shared unit has a one-cycle registered return; adds a DRAIN state.

module act_sched_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_z,
  input  logic [DATA_W-1:0] z_in,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] a_in,
  output logic [DATA_W-1:0] z_o,
  output logic [DATA_W-1:0] a_o
);
  logic [DATA_W-1:0] z_d, z_q, a_d, a_q;

  always_comb begin
    z_d = z_q;
    a_d = a_q;
    if (ld_z)   z_d = z_in;
    if (cap_en) a_d = a_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= '0;
      a_q <= '0;
    end else begin
      z_q <= z_d;
      a_q <= a_d;
    end
  end

  assign z_o = z_q;
  assign a_o = a_q;
endmodule

module activation_scheduler #(
  parameter int N_NEURONS = 2,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  activation_scheduler_if.slave  bus
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);

`ifdef ACT_SCHED_REG_RETURN_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
`endif

  state_e                           state_d, state_q;
  logic [IDX_W-1:0]                 issue_d, issue_q;
  logic [IDX_W-1:0]                 cap_d, cap_q;
  logic                             ld_z, cap_fire, run;
  logic                             in_ready, out_valid, busy;
  logic [DATA_W-1:0]                fn_z;
  logic [N_NEURONS-1:0]             cap_en;
  logic [N_NEURONS-1:0][DATA_W-1:0] z_in, z_lane, a_lane;

  assign z_in = bus.in_z;

  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    cap_d     = cap_q;
    ld_z      = 1'b0;
    cap_fire  = 1'b0;
    run       = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          ld_z    = 1'b1;
          issue_d = '0;
          cap_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        run  = 1'b1;
        busy = 1'b1;
`ifdef ACT_SCHED_REG_RETURN_EN
        // result of the element issued last cycle is on fn_a now
        cap_fire = (issue_q != '0);
        if (issue_q == LAST) state_d = ST_DRAIN;
`else
        cap_fire = 1'b1;
        if (issue_q == LAST) state_d = ST_DONE;
`endif
        else issue_d = issue_q + 1'b1;
      end
`ifdef ACT_SCHED_REG_RETURN_EN
      ST_DRAIN: begin
        busy     = 1'b1;
        cap_fire = 1'b1;
        state_d  = ST_DONE;
      end
`endif
      ST_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (cap_fire && cap_q != LAST) cap_d = cap_q + 1'b1;
  end

  always_comb begin
    fn_z   = '0;
    cap_en = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (run && issue_q == IDX_W'(i)) fn_z = z_lane[i];
      cap_en[i] = cap_fire && (cap_q == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      issue_q <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      cap_q   <= cap_d;
    end
  end

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_lane
    act_sched_lane #(.DATA_W(DATA_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .ld_z   (ld_z),
      .z_in   (z_in[g]),
      .cap_en (cap_en[g]),
      .a_in   (bus.fn_a),
      .z_o    (z_lane[g]),
      .a_o    (a_lane[g])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.fn_z      = fn_z;
  assign bus.out_a     = a_lane;
endmodule

// File: tb/tb_activation_scheduler.sv
// Directed bench: three schedulers (N=2, 5, 1), each with an XOR-5A stub as the shared unit.
module tb_activation_scheduler;
`ifdef ACT_SCHED_REG_RETURN_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  activation_scheduler_if #(.N_NEURONS(2), .DATA_W(8)) if2 ();
  activation_scheduler_if #(.N_NEURONS(5), .DATA_W(8)) if5 ();
  activation_scheduler_if #(.N_NEURONS(1), .DATA_W(8)) if1 ();

  activation_scheduler #(.N_NEURONS(2), .DATA_W(8), .IDX_W(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  activation_scheduler #(.N_NEURONS(5), .DATA_W(8), .IDX_W(3)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));
  activation_scheduler #(.N_NEURONS(1), .DATA_W(8), .IDX_W(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

`ifdef ACT_SCHED_REG_RETURN_EN
  always @(posedge clk) begin
    if2.fn_a <= if2.fn_z ^ 8'h5A;
    if5.fn_a <= if5.fn_z ^ 8'h5A;
    if1.fn_a <= if1.fn_z ^ 8'h5A;
  end
`else
  assign if2.fn_a = if2.fn_z ^ 8'h5A;
  assign if5.fn_a = if5.fn_z ^ 8'h5A;
  assign if1.fn_a = if1.fn_z ^ 8'h5A;
`endif

  // index 0 = N2, 1 = N5, 2 = N1
  logic [2:0]  iv, ordy, ov, ir, bz;
  logic [63:0] iz [3];
  logic [63:0] oa [3];
  logic [7:0]  fz [3];

  assign if2.in_valid = iv[0];   assign if2.out_ready = ordy[0];  assign if2.in_z = iz[0][15:0];
  assign if5.in_valid = iv[1];   assign if5.out_ready = ordy[1];  assign if5.in_z = iz[1][39:0];
  assign if1.in_valid = iv[2];   assign if1.out_ready = ordy[2];  assign if1.in_z = iz[2][7:0];
  assign ov[0] = if2.out_valid;  assign ir[0] = if2.in_ready;  assign bz[0] = if2.busy;
  assign ov[1] = if5.out_valid;  assign ir[1] = if5.in_ready;  assign bz[1] = if5.busy;
  assign ov[2] = if1.out_valid;  assign ir[2] = if1.in_ready;  assign bz[2] = if1.busy;
  assign oa[0] = {48'b0, if2.out_a};  assign fz[0] = if2.fn_z;
  assign oa[1] = {24'b0, if5.out_a};  assign fz[1] = if5.fn_z;
  assign oa[2] = {56'b0, if1.out_a};  assign fz[2] = if1.fn_z;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one vector, follow it through issue and completion; returns at the negedge out_valid is seen.
  task automatic do_vec(input int d, input int n, input logic [63:0] z, input logic rdy,
                        input int prev, output int acc);
    int t;
    logic [63:0] exp;
    iz[d] = z; iv[d] = 1'b1; ordy[d] = rdy;
    t = 0;
    while (!ir[d] && t < 50) begin @(negedge clk); t++; end
    chk("accept_rdy", {63'b0, ir[d]}, 64'd1);
    acc = cyc;
    if (prev >= 0) chk("spacing", 64'(acc - prev), 64'(n + 2 + XL));
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (j == 0) iz[d] = ~z;
      chk("fn_z", {56'b0, fz[d]}, {56'b0, z[j*8 +: 8]});
    end
    t = 0;
    while (!ov[d] && t < 20) begin @(negedge clk); t++; end
    chk("latency", 64'(cyc - acc - 1), 64'(n + XL));
    exp = '0;
    for (int j = 0; j < n; j++) exp[j*8 +: 8] = z[j*8 +: 8] ^ 8'h5A;
    chk("out_a", oa[d], exp);
  endtask

  initial begin
    int acc, prev;
    logic [63:0] v5 [3];
    logic [63:0] v1 [4];
    v5[0] = 64'h01_02_03_04_05; v5[1] = 64'h80_FF_7F_00_5A; v5[2] = 64'hDE_AD_BE_EF_11;
    v1[0] = 64'h00; v1[1] = 64'h5A; v1[2] = 64'hA5; v1[3] = 64'hFF;
    rst_n = 1'b0; iv = '0; ordy = '0;
    for (int k = 0; k < 3; k++) iz[k] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'b0, ir[0]}, 64'd1);
    chk("rst_out_valid", {63'b0, ov[0]}, 64'd0);
    chk("rst_fn_z", {56'b0, fz[0]}, 64'd0);
    chk("rst_out_a", oa[0], 64'd0);
    chk("rst_busy", {63'b0, bz[0]}, 64'd0);
    chk("rst_busy5", {63'b0, bz[1]}, 64'd0);

    // main vector, then hold in DONE with new data offered
    do_vec(0, 2, 64'hC235, 1'b0, -1, acc);
    chk("out_a_c235", oa[0], 64'h986F);
    iz[0] = 64'h7777;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", {63'b0, ov[0]}, 64'd1);
      chk("hold_out_a", oa[0], 64'h986F);
      chk("hold_in_ready", {63'b0, ir[0]}, 64'd0);
    end
    ordy[0] = 1'b1; iv[0] = 1'b0;
    @(negedge clk);
    chk("release_valid", {63'b0, ov[0]}, 64'd0);
    chk("release_in_ready", {63'b0, ir[0]}, 64'd1);
    chk("release_out_a", oa[0], 64'h986F);

    // reset mid-flight, after the first capture
    iz[0] = 64'h8001; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (1 + XL) @(negedge clk);
    chk("pre_rst_busy", {63'b0, bz[0]}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {63'b0, ir[0]}, 64'd1);
    chk("mid_rst_out_valid", {63'b0, ov[0]}, 64'd0);
    chk("mid_rst_busy", {63'b0, bz[0]}, 64'd0);
    chk("mid_rst_fn_z", {56'b0, fz[0]}, 64'd0);
    chk("mid_rst_out_a", oa[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_vec(0, 2, 64'h00A5, 1'b1, -1, acc);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);

    // back-to-back, N=5
    prev = -1;
    for (int k = 0; k < 3; k++) begin
      do_vec(1, 5, v5[k], 1'b1, prev, acc);
      prev = acc;
    end
    iv[1] = 1'b0;
    repeat (3) @(negedge clk);

    // back-to-back, N=1
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      do_vec(2, 1, v1[k], 1'b1, prev, acc);
      prev = acc;
    end
    iv[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("end_idle5", {63'b0, ir[1]}, 64'd1);
    chk("end_idle1", {63'b0, ir[2]}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
